// File: rtl/timebase_hms_gen.sv
// Real-time timebase: clock prescaler cascaded into ticks, seconds, minutes and hours,
// with a valid/ready time-load port. Optional alarm comparator enabled by macro ALARM_EN.
module timebase_hms_gen #(
  parameter int unsigned CYCLES_PER_TICK = 1024,
  parameter int unsigned TICKS_PER_SEC   = 2,
  parameter int unsigned HRS_W           = 7,
  parameter int unsigned HRS_MAX         = 99,
  parameter int unsigned CUM_W           = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [HRS_W-1:0]   set_hrs,
  input  logic [5:0]         set_min,
  input  logic [5:0]         set_sec,
  output logic               set_err,
  output logic               tick_pulse,
  output logic               sec_pulse,
  output logic               min_pulse,
  output logic               hr_pulse,
  output logic [HRS_W+11:0]  hms_time,
  output logic [CUM_W-1:0]   tick_cum,
  output logic               cum_sat
`ifdef ALARM_EN
  ,
  input  logic [HRS_W-1:0]   alarm_hrs,
  input  logic [5:0]         alarm_min,
  input  logic [5:0]         alarm_sec,
  input  logic               alarm_arm,
  output logic               alarm_pulse
`endif
);

  localparam int unsigned PW = $clog2(CYCLES_PER_TICK);
  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PW-1:0]    PCNT_LAST = PW'(CYCLES_PER_TICK - 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [HRS_W-1:0] HRS_LAST  = HRS_W'(HRS_MAX);

  logic [PW-1:0]    pcnt,     pcnt_n;
  logic [TW-1:0]    tick_cnt, tick_n;
  logic [5:0]       secs,     secs_n;
  logic [5:0]       mins,     mins_n;
  logic [HRS_W-1:0] hrs,      hrs_n;
  logic [CUM_W-1:0] cum_n;
  logic             sat_n;

  logic accept, load_ok, load, term, adv;
  logic tick_wrap, sec_wrap, min_wrap, hr_wrap;

  assign accept  = set_valid && set_ready;
  assign load_ok = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hrs <= HRS_LAST);
  assign load    = accept && load_ok;
  assign term    = enable && (pcnt == PCNT_LAST);
  // A valid load on the terminal cycle swallows that tick entirely.
  assign adv     = term && !load;

  // Wrap conditions are derived from current values so every level updates on the same edge.
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign sec_wrap  = adv && tick_wrap;
  assign min_wrap  = sec_wrap && (secs == 6'd59);
  assign hr_wrap   = min_wrap && (mins == 6'd59);

  always_comb begin
    pcnt_n = pcnt;
    tick_n = tick_cnt;
    secs_n = secs;
    mins_n = mins;
    hrs_n  = hrs;
    cum_n  = tick_cum;
    sat_n  = cum_sat;
    if (load) begin
      pcnt_n = '0;
      tick_n = '0;
      secs_n = set_sec;
      mins_n = set_min;
      hrs_n  = set_hrs;
    end else if (enable) begin
      pcnt_n = term ? '0 : pcnt + 1'b1;
      if (adv) begin
        tick_n = tick_wrap ? '0 : tick_cnt + 1'b1;
        if (tick_cum != '1) begin
          cum_n = tick_cum + 1'b1;
          if (cum_n == '1) sat_n = 1'b1;
        end
      end
      if (sec_wrap) secs_n = (secs == 6'd59) ? 6'd0 : secs + 6'd1;
      if (min_wrap) mins_n = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
      if (hr_wrap)  hrs_n  = (hrs == HRS_LAST) ? '0 : hrs + 1'b1;
    end
  end

`ifdef ALARM_EN
  logic alarm_hit;
  // Only cascade-driven time changes can fire the alarm; loads never do.
  assign alarm_hit = sec_wrap && alarm_arm &&
                     ({hrs_n, mins_n, secs_n} == {alarm_hrs, alarm_min, alarm_sec});
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      pcnt       <= '0;
      tick_cnt   <= '0;
      secs       <= '0;
      mins       <= '0;
      hrs        <= '0;
      tick_cum   <= '0;
      cum_sat    <= 1'b0;
      tick_pulse <= 1'b0;
      sec_pulse  <= 1'b0;
      min_pulse  <= 1'b0;
      hr_pulse   <= 1'b0;
      set_err    <= 1'b0;
      set_ready  <= 1'b0;
`ifdef ALARM_EN
      alarm_pulse <= 1'b0;
`endif
    end else begin
      pcnt       <= pcnt_n;
      tick_cnt   <= tick_n;
      secs       <= secs_n;
      mins       <= mins_n;
      hrs        <= hrs_n;
      tick_cum   <= cum_n;
      cum_sat    <= sat_n;
      tick_pulse <= adv;
      sec_pulse  <= sec_wrap;
      min_pulse  <= min_wrap;
      hr_pulse   <= hr_wrap;
      set_err    <= accept && !load_ok;
      set_ready  <= !accept;
`ifdef ALARM_EN
      alarm_pulse <= alarm_hit;
`endif
    end
  end

  assign hms_time = {hrs, mins, secs};

endmodule

// File: tb/tb_timebase_hms_gen.sv
// Directed self-checking bench for timebase_hms_gen (small prescaler, HRS_MAX=2, CUM_W=4).
module tb_timebase_hms_gen;

  localparam int unsigned HRS_W = 7;
  localparam int unsigned CUM_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              set_valid = 1'b0;
  logic              set_ready;
  logic [HRS_W-1:0]  set_hrs = '0;
  logic [5:0]        set_min = '0;
  logic [5:0]        set_sec = '0;
  logic              set_err;
  logic              tick_pulse, sec_pulse, min_pulse, hr_pulse;
  logic [HRS_W+11:0] hms_time;
  logic [CUM_W-1:0]  tick_cum;
  logic              cum_sat;
`ifdef ALARM_EN
  logic [HRS_W-1:0]  alarm_hrs = '0;
  logic [5:0]        alarm_min = '0;
  logic [5:0]        alarm_sec = '0;
  logic              alarm_arm = 1'b0;
  logic              alarm_pulse;
`endif

  int unsigned tests  = 0;
  int unsigned failed = 0;

  timebase_hms_gen #(
    .CYCLES_PER_TICK(4),
    .TICKS_PER_SEC  (2),
    .HRS_W          (HRS_W),
    .HRS_MAX        (2),
    .CUM_W          (CUM_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_hrs    (set_hrs),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .set_err    (set_err),
    .tick_pulse (tick_pulse),
    .sec_pulse  (sec_pulse),
    .min_pulse  (min_pulse),
    .hr_pulse   (hr_pulse),
    .hms_time   (hms_time),
    .tick_cum   (tick_cum),
    .cum_sat    (cum_sat)
`ifdef ALARM_EN
    ,
    .alarm_hrs  (alarm_hrs),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .alarm_arm  (alarm_arm),
    .alarm_pulse(alarm_pulse)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [HRS_W+11:0] hms(input int unsigned h, input int unsigned m,
                                            input int unsigned s);
    return {HRS_W'(h), 6'(m), 6'(s)};
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input int unsigned h, input int unsigned m, input int unsigned s);
    int unsigned w = 0;
    while (!set_ready && w < 10) begin
      step(1);
      w++;
    end
    tests++;
    if (set_ready !== 1'b1) begin
      failed++;
      $display("FAIL load_ready_wait got=%b exp=1", set_ready);
    end
    set_hrs   = HRS_W'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
    tests++;
    if (hms_time !== hms(h, m, s)) begin
      failed++;
      $display("FAIL load_value got=%h exp=%h", hms_time, hms(h, m, s));
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b0;
    step(2);
    tests++;
    if ({tick_pulse, sec_pulse, min_pulse, hr_pulse, set_err, cum_sat, set_ready} !== 7'b0 ||
        hms_time !== '0 || tick_cum !== '0) begin
      failed++;
      $display("FAIL reset_state flags=%b hms=%h cum=%0d exp all zero",
               {tick_pulse, sec_pulse, min_pulse, hr_pulse, set_err, cum_sat, set_ready},
               hms_time, tick_cum);
    end
  endtask

  task automatic test_run;
    logic [1:0] exp;
    reset = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step(1);
      if (n == 1) begin
        tests++;
        if (set_ready !== 1'b1) begin
          failed++;
          $display("FAIL ready_after_release got=%b exp=1", set_ready);
        end
      end
      exp = {(n % 4) == 0, (n % 8) == 0};
      tests++;
      if ({tick_pulse, sec_pulse, min_pulse, hr_pulse} !== {exp, 2'b00}) begin
        failed++;
        $display("FAIL run_pulses cycle=%0d got=%b exp=%b", n,
                 {tick_pulse, sec_pulse, min_pulse, hr_pulse}, {exp, 2'b00});
      end
      if (n == 8 || n == 16) begin
        tests++;
        if (hms_time !== hms(0, 0, n / 8)) begin
          failed++;
          $display("FAIL run_secs cycle=%0d got=%h exp=%h", n, hms_time, hms(0, 0, n / 8));
        end
      end
    end
    tests++;
    if (tick_cum !== 4'd4) begin
      failed++;
      $display("FAIL run_cum got=%0d exp=4", tick_cum);
    end
  endtask

  task automatic test_load_on_terminal;
    step(3);
    set_hrs = '0; set_min = 6'd0; set_sec = 6'd30;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
    tests++;
    if (hms_time !== hms(0, 0, 30) || tick_pulse !== 1'b0 || tick_cum !== 4'd4 ||
        set_ready !== 1'b0) begin
      failed++;
      $display("FAIL load_on_term hms=%h tick=%b cum=%0d rdy=%b exp hms=%h tick=0 cum=4 rdy=0",
               hms_time, tick_pulse, tick_cum, set_ready, hms(0, 0, 30));
    end
    step(3);
    tests++;
    if (tick_pulse !== 1'b0) begin
      failed++;
      $display("FAIL load_pcnt_cleared tick=%b exp=0", tick_pulse);
    end
    step(1);
    tests++;
    if (tick_pulse !== 1'b1 || tick_cum !== 4'd5 || hms_time !== hms(0, 0, 30)) begin
      failed++;
      $display("FAIL tick_after_load tick=%b cum=%0d hms=%h exp tick=1 cum=5 hms=%h",
               tick_pulse, tick_cum, hms_time, hms(0, 0, 30));
    end
  endtask

  task automatic test_saturation;
    step(36);
    tests++;
    if (tick_cum !== 4'd14 || cum_sat !== 1'b0) begin
      failed++;
      $display("FAIL cum_pre_sat cum=%0d sat=%b exp cum=14 sat=0", tick_cum, cum_sat);
    end
    step(4);
    tests++;
    if (tick_cum !== 4'd15 || cum_sat !== 1'b1 || tick_pulse !== 1'b1) begin
      failed++;
      $display("FAIL cum_sat cum=%0d sat=%b tick=%b exp cum=15 sat=1 tick=1",
               tick_cum, cum_sat, tick_pulse);
    end
    step(8);
    tests++;
    if (tick_cum !== 4'd15 || cum_sat !== 1'b1) begin
      failed++;
      $display("FAIL cum_hold cum=%0d sat=%b exp cum=15 sat=1", tick_cum, cum_sat);
    end
  endtask

  task automatic test_rollover;
    do_load(0, 0, 59);
    step(4);
    tests++;
    if ({tick_pulse, sec_pulse} !== 2'b10 || hms_time !== hms(0, 0, 59)) begin
      failed++;
      $display("FAIL mid_second tick/sec=%b hms=%h exp 10 hms=%h",
               {tick_pulse, sec_pulse}, hms_time, hms(0, 0, 59));
    end
    step(4);
    tests++;
    if (hms_time !== hms(0, 1, 0) || {sec_pulse, min_pulse, hr_pulse} !== 3'b110) begin
      failed++;
      $display("FAIL min_roll hms=%h pulses=%b exp hms=%h pulses=110",
               hms_time, {sec_pulse, min_pulse, hr_pulse}, hms(0, 1, 0));
    end
    step(1);
    tests++;
    if ({tick_pulse, sec_pulse, min_pulse, hr_pulse} !== 4'b0) begin
      failed++;
      $display("FAIL pulse_width got=%b exp=0000", {tick_pulse, sec_pulse, min_pulse, hr_pulse});
    end
    do_load(0, 59, 59);
    step(8);
    tests++;
    if (hms_time !== hms(1, 0, 0) || {sec_pulse, min_pulse, hr_pulse} !== 3'b111) begin
      failed++;
      $display("FAIL hr_roll hms=%h pulses=%b exp hms=%h pulses=111",
               hms_time, {sec_pulse, min_pulse, hr_pulse}, hms(1, 0, 0));
    end
    do_load(2, 59, 59);
    step(8);
    tests++;
    if (hms_time !== hms(0, 0, 0) || {sec_pulse, min_pulse, hr_pulse} !== 3'b111) begin
      failed++;
      $display("FAIL hrs_wrap hms=%h pulses=%b exp hms=0 pulses=111",
               hms_time, {sec_pulse, min_pulse, hr_pulse});
    end
  endtask

  task automatic test_pause;
    do_load(0, 0, 0);
    step(2);
    enable = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step(1);
      tests++;
      if ({tick_pulse, sec_pulse, min_pulse, hr_pulse} !== 4'b0 || hms_time !== '0) begin
        failed++;
        $display("FAIL paused cycle=%0d pulses=%b hms=%h exp 0000 hms=0", n,
                 {tick_pulse, sec_pulse, min_pulse, hr_pulse}, hms_time);
      end
    end
    enable = 1'b1;
    step(1);
    tests++;
    if (tick_pulse !== 1'b0) begin
      failed++;
      $display("FAIL resume_early tick=%b exp=0", tick_pulse);
    end
    step(1);
    tests++;
    if (tick_pulse !== 1'b1) begin
      failed++;
      $display("FAIL resume_tick tick=%b exp=1", tick_pulse);
    end
  endtask

  task automatic test_set_err;
    set_hrs = '0; set_min = 6'd0; set_sec = 6'd60;
    set_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step(1);
      tests++;
      if (set_err !== (n != 2) || set_ready !== (n == 2) || hms_time !== '0) begin
        failed++;
        $display("FAIL bad_load cycle=%0d err=%b rdy=%b hms=%h exp err=%b rdy=%b hms=0",
                 n, set_err, set_ready, hms_time, n != 2, n == 2);
      end
    end
    set_valid = 1'b0;
    step(1);
    tests++;
    if (set_err !== 1'b0 || set_ready !== 1'b1) begin
      failed++;
      $display("FAIL err_clear err=%b rdy=%b exp err=0 rdy=1", set_err, set_ready);
    end
  endtask

  task automatic test_reset_mid;
    do_load(0, 0, 5);
    step(5);
    reset = 1'b0;
    set_hrs = HRS_W'(1); set_min = 6'd2; set_sec = 6'd3;
    set_valid = 1'b1;
    step(1);
    tests++;
    if ({tick_pulse, sec_pulse, min_pulse, hr_pulse, set_err, cum_sat, set_ready} !== 7'b0 ||
        hms_time !== '0 || tick_cum !== '0) begin
      failed++;
      $display("FAIL reset_mid flags=%b hms=%h cum=%0d exp all zero",
               {tick_pulse, sec_pulse, min_pulse, hr_pulse, set_err, cum_sat, set_ready},
               hms_time, tick_cum);
    end
    reset = 1'b1;
    step(1);
    tests++;
    if (set_ready !== 1'b1 || hms_time !== '0) begin
      failed++;
      $display("FAIL ready_release rdy=%b hms=%h exp rdy=1 hms=0", set_ready, hms_time);
    end
    step(1);
    set_valid = 1'b0;
    tests++;
    if (hms_time !== hms(1, 2, 3) || set_ready !== 1'b0) begin
      failed++;
      $display("FAIL load_after_release hms=%h rdy=%b exp hms=%h rdy=0",
               hms_time, set_ready, hms(1, 2, 3));
    end
  endtask

`ifdef ALARM_EN
  task automatic test_alarm;
    int unsigned hits = 0;
    reset = 1'b0;
    alarm_hrs = '0; alarm_min = 6'd0; alarm_sec = 6'd2;
    alarm_arm = 1'b1;
    step(1);
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (alarm_pulse === 1'b1) hits++;
      if (n == 16) begin
        tests++;
        if (alarm_pulse !== 1'b1) begin
          failed++;
          $display("FAIL alarm_at_16 got=%b exp=1", alarm_pulse);
        end
      end
    end
    tests++;
    if (hits != 1) begin
      failed++;
      $display("FAIL alarm_count got=%0d exp=1", hits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_load_on_terminal();
    test_saturation();
    test_rollover();
    test_pause();
    test_set_err();
    test_reset_mid();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
